// File: rtl/slave_mem_arbiter_pkg.sv
// Purpose: shared types and helpers for the slave memory arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package slave_mem_arbiter_pkg;

    // Request-type encoding carried on the per-requester wr bit
    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    // Arbiter ownership state
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Next rotating index, wrapping modulo n (works for non power-of-two n)
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/slave_mem_arb_pick.sv
// Purpose: first-set picker starting at a rotating index, one-hot or zero result.
// Latency: combinational.
// Backpressure: none; i_en low forces a zero grant.
module slave_mem_arb_pick #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    // Scan from i_start upward with wraparound and take the first request seen
    always_comb begin
        o_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_idx = IW'((32'(i_start) + 32'(k)) % 32'(N));
            if (i_en && !w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slave_mem_arbiter.sv
// Purpose: arbitrate a 1-cycle-latency single-port BRAM among NUM_REQ requesters (RR when SLAVE_MEM_ARB_RR_EN, else fixed priority; bounded locked bursts).
// Latency: accept at T, registered mem strobe at T+1, rvalid/rdata at T+2; one access per cycle.
// Backpressure: requesters hold req until gnt; gnt is combinational and zero while in reset.
module slave_mem_arbiter
    import slave_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    parameter int MAX_BURST  = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              lock,
    input  logic [NUM_REQ-1:0]              wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              rvalid,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            mem_wen,
    output logic                            mem_ren,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam bit LOCK_OK = (MAX_BURST > 1);

    arb_state_t             r_state;
    logic [IDX_W-1:0]       r_owner;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       w_start;
    logic [NUM_REQ-1:0]     w_pick_gnt;
    logic [NUM_REQ-1:0]     w_owner_oh;
    logic [IDX_W-1:0]       w_gidx;
    logic                   w_acc;
    logic                   w_sel_wr;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_p1_vld;
    logic [IDX_W-1:0]       r_p1_idx;
    logic [NUM_REQ-1:0]     w_p1_oh;
    logic [NUM_REQ-1:0]     r_rvalid;

`ifdef SLAVE_MEM_ARB_RR_EN
    logic [IDX_W-1:0]       r_ptr;
    assign w_start = r_ptr;
`else
    assign w_start = '0;
`endif

    slave_mem_arb_pick #(.N(NUM_REQ)) u_pick (
        .i_req   (req),
        .i_start (w_start),
        .i_en    (r_state == ST_IDLE),
        .o_gnt   (w_pick_gnt)
    );

    // Grant: picker in IDLE, owner only in LOCKED; also decode the granted slice
    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
        if (!rstn)
            gnt = '0;
        else if (r_state == ST_IDLE)
            gnt = w_pick_gnt;
        else
            gnt = w_owner_oh & req;
        w_gidx      = '0;
        w_sel_wr    = REQ_READ;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                w_gidx      = IDX_W'(i);
                w_sel_wr    = wr[i];
                w_sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        w_acc     = |(gnt & req);
        w_cnt_nxt = r_cnt + 1'b1;
        w_p1_oh           = '0;
        w_p1_oh[r_p1_idx] = r_p1_vld;
    end

    // Ownership FSM: burst entry, counting, release and pointer update
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_cnt   <= '0;
`ifdef SLAVE_MEM_ARB_RR_EN
            r_ptr   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        if (lock[w_gidx] && LOCK_OK) begin
                            r_state <= ST_LOCKED;
                            r_owner <= w_gidx;
                            r_cnt   <= CNT_W'(1);
                        end else begin
`ifdef SLAVE_MEM_ARB_RR_EN
                            r_ptr <= IDX_W'(next_idx(32'(w_gidx), NUM_REQ));
`endif
                        end
                    end
                end
                ST_LOCKED: begin
                    // Release on an unlocked grant, a full burst, or lock dropped while idle
                    if ((req[r_owner] && (!lock[r_owner] || w_cnt_nxt == CNT_W'(MAX_BURST))) ||
                        (!req[r_owner] && !lock[r_owner])) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
`ifdef SLAVE_MEM_ARB_RR_EN
                        r_ptr   <= IDX_W'(next_idx(32'(r_owner), NUM_REQ));
`endif
                    end else if (req[r_owner]) begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Memory command register; address/data hold when nothing is accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_wen <= w_acc && (w_sel_wr == REQ_WRITE);
            mem_ren <= w_acc && (w_sel_wr == REQ_READ);
            if (w_acc) begin
                mem_addr  <= w_sel_addr;
                mem_wdata <= w_sel_wdata;
            end
        end
    end

    // Two-stage read-return pipe steering rvalid back to the issuing requester
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_p1_vld <= 1'b0;
            r_p1_idx <= '0;
            r_rvalid <= '0;
        end else begin
            r_p1_vld <= w_acc && (w_sel_wr == REQ_READ);
            r_p1_idx <= w_gidx;
            r_rvalid <= w_p1_oh;
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = mem_rdata;

endmodule

// File: tb/tb_slave_mem_arbiter.sv
module tb_slave_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int NR = 2;

    logic           clk;
    logic           rstn;
    logic [NR-1:0]  req, lock, wr;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wdata;
    logic [NR-1:0]  gnt, rvalid;
    logic [DW-1:0]  rdata;
    logic           mem_wen, mem_ren;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;

    slave_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(16)) dut (
        .clk(clk), .rstn(rstn), .req(req), .lock(lock), .wr(wr), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port BRAM, read latency one clock
    logic [DW-1:0] mem [4096];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          wen;
        logic          ren;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;
    typedef struct packed {
        logic [NR-1:0] oh;
        logic [DW-1:0] d;
    } rd_t;

    cmd_t cmd_q[$];
    rd_t  rd_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: pop and compare whenever the DUT presents a strobe or read return
    always @(negedge clk) begin
        if (rstn) begin
            if (mem_wen || mem_ren) begin
                cmd_t got, exp;
                got = '{mem_wen, mem_ren, mem_addr, mem_wdata};
                checks++;
                if (cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_cmd unexpected got %h", got);
                end else begin
                    exp = cmd_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL mem_cmd got %h want %h", got, exp);
                    end
                end
            end
            if (rvalid != '0) begin
                rd_t got, exp;
                got = '{rvalid, rdata};
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid unexpected got %h", got);
                end else begin
                    exp = rd_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL rdata got oh=%b d=%h want oh=%b d=%h", got.oh, got.d, exp.oh, exp.d);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    // One cycle of stimulus; expected grant checked here, expected responses queued
    task automatic step(input logic [1:0] rq, input logic [1:0] lk, input logic [1:0] w,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [1:0] eg, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                        input string nm);
        int g;
        req = rq; lock = lk; wr = w;
        addr = {a1, a0}; wdata = {d1, d0};
        @(negedge clk);
        chk({"gnt_", nm}, 32'(gnt), 32'(eg));
        if (eg != 2'b00) begin
            g = eg[1] ? 1 : 0;
            cmd_q.push_back('{w[g], ~w[g], (g == 1) ? a1 : a0, (g == 1) ? d1 : d0});
            if (!w[g]) rd_q.push_back('{eg, (g == 1) ? e1 : e0});
        end
        @(posedge clk); #1;
    endtask

    // Read-only shorthand: requester 0 reads 0x123, requester 1 reads 0x456
    task automatic rd_step(input logic [1:0] rq, input logic [1:0] lk, input logic [1:0] eg,
                           input logic [DW-1:0] e0, input logic [DW-1:0] e1, input string nm);
        step(rq, lk, 2'b00, 12'h123, 12'h456, 8'h00, 8'h00, eg, e0, e1, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; req = '0; lock = '0; wr = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",   32'(gnt), 0);
        chk("rst_rvld",  32'(rvalid), 0);
        chk("rst_wen",   32'(mem_wen), 0);
        chk("rst_ren",   32'(mem_ren), 0);
        chk("rst_addr",  32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single requester write then read
        step(2'b01, 2'b00, 2'b01, 12'h123, 12'h000, 8'hA5, 8'h00, 2'b01, 8'h00, 8'h00, "wr0");
        step(2'b01, 2'b00, 2'b00, 12'h123, 12'h000, 8'h11, 8'h00, 2'b01, 8'hA5, 8'h00, "rd0");
        step(2'b10, 2'b00, 2'b10, 12'h000, 12'h456, 8'h00, 8'h3C, 2'b10, 8'h00, 8'h00, "wr1");

        // Both requesting, no lock
`ifdef SLAVE_MEM_ARB_RR_EN
        rd_step(2'b11, 2'b00, 2'b01, 8'hA5, 8'h3C, "fair0");
        rd_step(2'b11, 2'b00, 2'b10, 8'hA5, 8'h3C, "fair1");
        rd_step(2'b11, 2'b00, 2'b01, 8'hA5, 8'h3C, "fair2");
        rd_step(2'b11, 2'b00, 2'b10, 8'hA5, 8'h3C, "fair3");
`else
        for (int i = 0; i < 4; i++) rd_step(2'b11, 2'b00, 2'b01, 8'hA5, 8'h3C, "fixed");
`endif

        // Back-to-back write then read of the same address
        step(2'b01, 2'b00, 2'b01, 12'h123, 12'h000, 8'h5A, 8'h00, 2'b01, 8'h00, 8'h00, "raw_wr");
        rd_step(2'b01, 2'b00, 2'b01, 8'h5A, 8'h3C, "raw_rd");

        // Locked burst of 16 by requester 1 while requester 0 waits
        rd_step(2'b10, 2'b10, 2'b10, 8'h5A, 8'h3C, "burst_first");
        for (int i = 0; i < 15; i++) rd_step(2'b11, 2'b10, 2'b10, 8'h5A, 8'h3C, "burst");
        rd_step(2'b11, 2'b10, 2'b01, 8'h5A, 8'h3C, "after_burst");
`ifdef SLAVE_MEM_ARB_RR_EN
        rd_step(2'b11, 2'b10, 2'b10, 8'h5A, 8'h3C, "regrant1");
        rd_step(2'b11, 2'b00, 2'b10, 8'h5A, 8'h3C, "unlock1");
`else
        rd_step(2'b11, 2'b10, 2'b01, 8'h5A, 8'h3C, "regrant0");
        rd_step(2'b11, 2'b00, 2'b01, 8'h5A, 8'h3C, "unlock0");
`endif

        // Owner idle with lock held, then lock dropped while idle
        rd_step(2'b10, 2'b10, 2'b10, 8'h5A, 8'h3C, "lk_take");
        rd_step(2'b01, 2'b10, 2'b00, 8'h5A, 8'h3C, "lk_hold");
        rd_step(2'b01, 2'b00, 2'b00, 8'h5A, 8'h3C, "lk_drop");
        rd_step(2'b01, 2'b00, 2'b01, 8'h5A, 8'h3C, "lk_after");

        // Release on a granted access with lock low; owner gets the release cycle
        rd_step(2'b10, 2'b10, 2'b10, 8'h5A, 8'h3C, "rel_take");
        rd_step(2'b11, 2'b00, 2'b10, 8'h5A, 8'h3C, "rel_gnt");
        rd_step(2'b11, 2'b00, 2'b01, 8'h5A, 8'h3C, "rel_next");

        // Reset one cycle after a locked read grant
        rd_step(2'b10, 2'b10, 2'b10, 8'h5A, 8'h3C, "pre_rst");
        rstn = 1'b0;
        cmd_q.delete();
        rd_q.delete();
        #1;
        chk("mid_rst_ren",  32'(mem_ren), 0);
        chk("mid_rst_wen",  32'(mem_wen), 0);
        chk("mid_rst_rvld", 32'(rvalid), 0);
        chk("mid_rst_gnt",  32'(gnt), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        rd_step(2'b11, 2'b00, 2'b01, 8'h5A, 8'h3C, "post_rst");
        for (int i = 0; i < 4; i++) rd_step(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, "drain");

        chk("cmd_q_empty", 32'(cmd_q.size()), 0);
        chk("rd_q_empty",  32'(rd_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
